lane_dispatcher: RTL and testbench
==================================

# lane_dispatcher

Credit-based round-robin dispatcher that sits directly upstream of the 1-to-4 4-bit demultiplexer. It accepts a 4-bit nibble stream over a valid/ready handshake, picks a destination lane, and drives the demux data and select inputs from registers. It tracks per-lane credits so no downstream lane is overrun. Downstream lanes return credits with single-cycle pulses.

## Interface
- CREDITS, 2: credits per lane after reset; legal range 1..3.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream nibble valid.
- in_data  in  4  upstream nibble.
- in_dest  in  2  explicit lane number; used only when LANE_DISPATCHER_ADDR_EN is defined, ignored otherwise.
- in_ready  out  1  dispatcher can accept `in_data` this cycle.
- credit_ret  in  4  one-hot-per-lane pulse; each set bit returns one credit to that lane.
- out_data  out  4  registered nibble to the demux data input.
- out_sel  out  2  registered lane select to the demux select input.
- out_valid  out  1  `out_data`/`out_sel` carry a new nibble this cycle.
- lane_full  out  4  bit i is 1 when lane i has 0 credits.
- credit_err  out  1  sticky flag: a credit was returned to a lane already holding CREDITS.

## Operation
- Reset values:
  - out_data = 0, out_sel = 0, out_valid = 0.
  - credit_err = 0, lane_full = 0.
  - All credit counters = CREDITS.
  - Round-robin pointer ptr = 0.
- Target selection (default build):
  - Target is the first lane with credit > 0, scanning ptr, ptr+1, ... modulo 4.
  - If all four lanes have 0 credits, in_ready = 0.
- Transfer occurs when `in_valid && in_ready`. On a transfer:
  - out_data ← in_data, out_sel ← target, out_valid ← 1.
  - credit[target] decrements.
  - ptr ← (target + 1) mod 4.
- No transfer in a cycle:
  - out_valid ← 0 and out_data ← 0, so all demux outputs go to 0.
  - out_sel holds its last value.
  - ptr holds.
- Credit counters are 2 bits wide.
  - Consume and return on the same lane in the same cycle: counter unchanged.
  - Return only: counter increments, saturating at CREDITS. A return at CREDITS leaves the counter unchanged and sets credit_err.
  - Multiple credit_ret bits may be set in one cycle; each lane is handled independently.
- credit_err clears only on rst_n.
- in_ready is combinational from the credit counters and ptr (plus in_dest in ADDR mode). It never depends on in_valid.
- Upstream must hold in_data (and in_dest) stable while in_valid = 1 and in_ready = 0.

## Timing
- Latency: transfer at edge N, so out_valid/out_data/out_sel are valid in the cycle after edge N and are seen by the demux in that cycle.
- Throughput: 1 nibble per cycle while credits remain.
- A credit returned in cycle N affects in_ready and lane_full from cycle N+1.
- lane_full is registered-consistent: it reflects the counter values after each edge.
- rst_n is asynchronous: asserting it mid-transfer forces every output to its reset value immediately, without waiting for a clock edge. Release is synchronised by the instantiating top.

## Configuration
- LANE_DISPATCHER_ADDR_EN defined:
  - Target = in_dest. The round-robin pointer is removed.
  - in_ready = (credit[in_dest] > 0), so a full destination stalls the input even if other lanes have credit.
- LANE_DISPATCHER_ADDR_EN undefined:
  - in_dest is ignored and the round-robin selection above applies.

## Structure
- Shared package dispatch_pkg:
  - NUM_LANES = 4, DATA_W = 4, SEL_W = 2.
  - lane_t (2-bit lane index typedef) and credit_t (2-bit counter typedef).
- Sub-module lane_credit_counter, instantiated 4 times:
  - Inputs: consume, ret.
  - Outputs: count, empty, overflow.
- Top-level logic: round-robin priority scan, output registers, sticky error flag.

## Test plan
- Back-to-back nibbles: after reset, CREDITS = 2, in_valid = 1 with nibbles 4'hA, 4'h5, 4'h3, 4'hC on consecutive cycles, no returns.
  - out_sel = 0, 1, 2, 3 and out_data = A, 5, 3, C, one cycle after each transfer.
  - in_ready stays 1.
- Exhaust all credits: 8 transfers with no returns.
  - The 9th cycle shows in_ready = 0 and lane_full = 4'hF.
  - Then a credit_ret = 4'b0100 pulse gives in_ready = 1 the next cycle, and the next nibble goes to out_sel = 2.
- Skip a full lane: drain lane 1 to 0 credits while the other lanes keep credit.
  - The next round skips lane 1: sequence 0, 2, 3, 0.
- Simultaneous consume and return: lane 0 at credit 1, transfer targeting lane 0 with credit_ret[0] = 1 in the same cycle.
  - Counter stays 1, lane_full[0] = 0.
- Overflow return: credit_ret = 4'b1000 while lane 3 holds 2 credits.
  - credit_err = 1 from the next cycle, the counter stays 2, and credit_err persists until reset.
- Mid-stream reset: assert rst_n = 0 between edges during streaming.
  - out_valid, out_data and out_sel go to 0 immediately.
  - After release, all lanes have 2 credits and ptr = 0.
  - With ADDR_EN defined: in_dest = 2 and lane 2 full gives in_ready = 0 even though lanes 0, 1 and 3 have credit.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types and sizes for the lane dispatcher and its credit counters.
package dispatch_pkg;

    localparam int NUM_LANES = 4;
    localparam int DATA_W    = 4;
    localparam int SEL_W     = 2;

    typedef logic [SEL_W-1:0] lane_t;
    typedef logic [1:0]       credit_t;

    // One-hot lane mask for a lane index.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_t lane);
        logic [NUM_LANES-1:0] mask;
        mask = {{(NUM_LANES-1){1'b0}}, 1'b1};
        return mask << lane;
    endfunction

endpackage

// File: rtl/lane_credit_counter.sv
// Per-lane credit counter: consume decrements, ret increments, saturating at
// CREDITS. A return while already full raises a single-cycle overflow.
module lane_credit_counter
    import dispatch_pkg::*;
#(
    parameter int CREDITS = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    consume,
    input  logic    ret,
    output credit_t count,
    output logic    empty,
    output logic    overflow
);

    credit_t count_q, count_d;

    // Next credit value and overflow detection.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        count_d  = count_q;
        overflow = 1'b0;
        if (consume && !ret) begin
            count_d = count_q - 2'd1;
        end else if (ret && !consume) begin
            if (count_q == credit_t'(CREDITS)) begin
                overflow = 1'b1;
            end else begin
                count_d = count_q + 2'd1;
            end
        end
    end

    // Credit register, full after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every flop updating from the
        // values sampled at the same edge.
        if (!rst_n) count_q <= credit_t'(CREDITS);
        else        count_q <= count_d;
    end

    assign count = count_q;
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/lane_dispatcher.sv
// Credit-based dispatcher feeding a 1-to-4 nibble demux. Default build picks
// lanes round-robin among those holding credit; defining
// LANE_DISPATCHER_ADDR_EN routes each nibble to in_dest instead.
module lane_dispatcher
    import dispatch_pkg::*;
#(
    parameter int CREDITS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [SEL_W-1:0]     in_dest,
    output logic                 in_ready,
    input  logic [NUM_LANES-1:0] credit_ret,
    output logic [DATA_W-1:0]    out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_valid,
    output logic [NUM_LANES-1:0] lane_full,
    output logic                 credit_err
);

    logic [NUM_LANES-1:0] empty;
    logic [NUM_LANES-1:0] overflow;
    logic [NUM_LANES-1:0] consume;
    credit_t              count [NUM_LANES];
    lane_t                target;
    logic                 transfer;

    logic [DATA_W-1:0] out_data_q, out_data_d;
    lane_t             out_sel_q, out_sel_d;
    logic              out_valid_q, out_valid_d;
    logic              credit_err_q, credit_err_d;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_credit_counter #(.CREDITS(CREDITS)) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .consume  (consume[g]),
            .ret      (credit_ret[g]),
            .count    (count[g]),
            .empty    (empty[g]),
            .overflow (overflow[g])
        );
        assign lane_full[g] = (count[g] == 2'd0);
    end

`ifdef LANE_DISPATCHER_ADDR_EN
    // Explicit addressing: the destination lane alone decides readiness.
    always_comb begin
        target   = in_dest;
        in_ready = !empty[in_dest];
    end
`else
    lane_t ptr_q, ptr_d;
    lane_t idx;
    logic  unused_in_dest;

    assign unused_in_dest = ^in_dest;

    // Round-robin scan from ptr; walking backwards lets the nearest lane win.
    always_comb begin
        target   = ptr_q;
        in_ready = 1'b0;
        idx      = ptr_q;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            idx = ptr_q + lane_t'(i);
            if (!empty[idx]) begin
                target   = idx;
                in_ready = 1'b1;
            end
        end
        ptr_d = transfer ? lane_t'(target + 2'd1) : ptr_q;
    end

    // Round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif

    // Handshake, credit consumption and next output register values.
    always_comb begin
        transfer     = in_valid && in_ready;
        consume      = transfer ? lane_onehot(target) : '0;
        out_valid_d  = transfer;
        out_data_d   = transfer ? in_data : '0;
        out_sel_d    = transfer ? target : out_sel_q;
        credit_err_d = credit_err_q | (|overflow);
    end

    // Output registers and sticky credit error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_sel_q    <= '0;
            out_valid_q  <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            out_valid_q  <= out_valid_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_sel    = out_sel_q;
    assign out_valid  = out_valid_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_lane_dispatcher.sv
// Scoreboard bench for lane_dispatcher (CREDITS = 2). The driver pushes the
// hand-computed lane/nibble of each accepted transfer; the monitor pops and
// compares whenever out_valid is seen. Covers LANE_DISPATCHER_ADDR_EN too.
module tb_lane_dispatcher;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic [1:0] in_dest;
    logic       in_ready;
    logic [3:0] credit_ret;
    logic [3:0] out_data;
    logic [1:0] out_sel;
    logic       out_valid;
    logic [3:0] lane_full;
    logic       credit_err;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    lane_dispatcher #(.CREDITS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_ready   (in_ready),
        .credit_ret (credit_ret),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .out_valid  (out_valid),
        .lane_full  (lane_full),
        .credit_err (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented nibble against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got sel %0d data %0h, want none", out_sel, out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_sel", 32'(out_sel), 32'(e.sel));
                    check("out_data", 32'(out_data), 32'(e.data));
                end
            end else begin
                check("idle_out_data", 32'(out_data), 32'h0);
            end
        end
    end

    // One cycle of stimulus, entered and left at posedge+1. in_ready is
    // checked mid-cycle; an accepted nibble is pushed with its expected lane.
    task automatic cycle(input logic v, input logic [3:0] d, input logic [3:0] ret,
                         input logic [1:0] sel, input logic rdy);
        in_valid   = v;
        in_data    = d;
        in_dest    = sel;
        credit_ret = ret;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(rdy));
        if (v && rdy) sb.push_back('{sel: sel, data: d});
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_data    = 4'h0;
        credit_ret = 4'h0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_sel", 32'(out_sel), 32'h0);
        check("rst_lane_full", 32'(lane_full), 32'h0);
        check("rst_credit_err", 32'(credit_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges right after a transfer became visible.
    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_out_data", 32'(out_data), 32'h0);
        check("midrst_out_sel", 32'(out_sel), 32'h0);
        check("midrst_lane_full", 32'(lane_full), 32'h0);
        check("midrst_credit_err", 32'(credit_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        in_valid   = 1'b0;
        in_data    = 4'h0;
        in_dest    = 2'd0;
        credit_ret = 4'h0;
        apply_reset();

`ifdef LANE_DISPATCHER_ADDR_EN
        // Drain lane 2 by address; it stalls while other lanes have credit.
        cycle(1'b1, 4'h1, 4'h0, 2'd2, 1'b1);
        cycle(1'b1, 4'h2, 4'h0, 2'd2, 1'b1);
        check("addr_lane_full", 32'(lane_full), 32'h4);
        cycle(1'b1, 4'h3, 4'h0, 2'd2, 1'b0);
        cycle(1'b1, 4'h4, 4'h0, 2'd0, 1'b1);
        cycle(1'b1, 4'h5, 4'h0, 2'd3, 1'b1);
        cycle(1'b1, 4'h6, 4'h0, 2'd3, 1'b1);
        cycle(1'b1, 4'h7, 4'h0, 2'd3, 1'b0);
        check("addr_lane_full2", 32'(lane_full), 32'hC);
        // Return to lane 2 while lane 2 is requested: stalls now, ready next.
        cycle(1'b1, 4'h8, 4'h4, 2'd2, 1'b0);
        cycle(1'b1, 4'h8, 4'h0, 2'd2, 1'b1);
        // Overflow on lane 1 (still at 2 credits).
        cycle(1'b0, 4'h0, 4'h2, 2'd0, 1'b1);
        check("addr_credit_err", 32'(credit_err), 32'h1);
        cycle(1'b1, 4'h9, 4'h0, 2'd1, 1'b1);
        mid_reset();
        cycle(1'b1, 4'hA, 4'h0, 2'd2, 1'b1);
        cycle(1'b1, 4'hB, 4'h0, 2'd2, 1'b1);
        cycle(1'b1, 4'hC, 4'h0, 2'd2, 1'b0);
`else
        // Back-to-back nibbles rotate through all lanes.
        cycle(1'b1, 4'hA, 4'h0, 2'd0, 1'b1);
        cycle(1'b1, 4'h5, 4'h0, 2'd1, 1'b1);
        cycle(1'b1, 4'h3, 4'h0, 2'd2, 1'b1);
        cycle(1'b1, 4'hC, 4'h0, 2'd3, 1'b1);
        // Exhaust the second credit of every lane.
        cycle(1'b1, 4'h1, 4'h0, 2'd0, 1'b1);
        cycle(1'b1, 4'h2, 4'h0, 2'd1, 1'b1);
        cycle(1'b1, 4'h3, 4'h0, 2'd2, 1'b1);
        cycle(1'b1, 4'h4, 4'h0, 2'd3, 1'b1);
        check("exhaust_lane_full", 32'(lane_full), 32'hF);
        // Stalled cycle; the lane-2 return only shows up after the edge.
        cycle(1'b1, 4'h7, 4'h4, 2'd0, 1'b0);
        check("ret2_lane_full", 32'(lane_full), 32'hB);
        cycle(1'b1, 4'h7, 4'h0, 2'd2, 1'b1);
        // Refill lanes 0, 2, 3 to 2 credits, leave lane 1 empty. ptr = 3.
        cycle(1'b0, 4'h0, 4'hD, 2'd0, 1'b0);
        cycle(1'b0, 4'h0, 4'hD, 2'd0, 1'b1);
        cycle(1'b1, 4'hB, 4'h0, 2'd3, 1'b1);
        // From ptr = 0 the scan skips empty lane 1.
        cycle(1'b1, 4'h1, 4'h0, 2'd0, 1'b1);
        cycle(1'b1, 4'h2, 4'h0, 2'd2, 1'b1);
        cycle(1'b1, 4'h3, 4'h0, 2'd3, 1'b1);
        cycle(1'b1, 4'h4, 4'h0, 2'd0, 1'b1);
        check("skip_lane_full", 32'(lane_full), 32'hB);
        // Get lane 0 to 1 credit as the only candidate from ptr = 3.
        cycle(1'b0, 4'h0, 4'h1, 2'd0, 1'b1);
        cycle(1'b1, 4'hD, 4'h0, 2'd2, 1'b1);
        // Consume and return on lane 0 together: stays at 1.
        cycle(1'b1, 4'h9, 4'h1, 2'd0, 1'b1);
        check("sim_lane_full", 32'(lane_full), 32'hE);
        cycle(1'b1, 4'hE, 4'h0, 2'd0, 1'b1);
        check("sim_drain_lane_full", 32'(lane_full), 32'hF);
        // Lane 3 back to 2 credits, then one return too many.
        cycle(1'b0, 4'h0, 4'h8, 2'd0, 1'b0);
        cycle(1'b0, 4'h0, 4'h8, 2'd0, 1'b1);
        check("pre_ovf_credit_err", 32'(credit_err), 32'h0);
        cycle(1'b0, 4'h0, 4'h8, 2'd0, 1'b1);
        check("ovf_credit_err", 32'(credit_err), 32'h1);
        check("ovf_lane_full", 32'(lane_full), 32'h7);
        // Counter held at 2: exactly two more nibbles go to lane 3.
        cycle(1'b1, 4'h6, 4'h0, 2'd3, 1'b1);
        cycle(1'b1, 4'h8, 4'h0, 2'd3, 1'b1);
        cycle(1'b1, 4'h5, 4'h0, 2'd0, 1'b0);
        check("sticky_credit_err", 32'(credit_err), 32'h1);
        // Refill all lanes, stream, then reset asynchronously mid-stream.
        cycle(1'b0, 4'h0, 4'hF, 2'd0, 1'b0);
        cycle(1'b0, 4'h0, 4'hF, 2'd0, 1'b1);
        cycle(1'b1, 4'h6, 4'h0, 2'd0, 1'b1);
        cycle(1'b1, 4'h8, 4'h0, 2'd1, 1'b1);
        mid_reset();
        // Fresh credits and ptr = 0: eight transfers in lane order, then stall.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 4'(i + 3), 4'h0, 2'(i), 1'b1);
        end
        cycle(1'b1, 4'hF, 4'h0, 2'd0, 1'b0);
        check("final_lane_full", 32'(lane_full), 32'hF);
`endif

        @(negedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
